// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder controller: feeds one nibble per cycle to an external
// 4-bit adder, collects the sum from the top, and reports carry and overflow.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    input  logic                   add_c3,
    output logic [1:0]             state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; in_ready is high only in IDLE, out_valid only in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic            carry;
    logic [CW-1:0]   cnt;

    // Operand registers drain to zero after the final shift and carry is
    // cleared on exit from RUN, so the adder inputs are 0 outside RUN.
    assign add_a     = a_sh[3:0];
    assign add_b     = b_sh[3:0];
    assign add_cin   = carry;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= op_a;
                        b_sh     <= op_b;
                        carry    <= cin;
                        cnt      <= '0;
                        res      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    res  <= {add_s, res[W-1:4]};
                    a_sh <= a_sh >> 4;
                    b_sh <= b_sh >> 4;
                    if (cnt == LAST) begin
                        sum       <= {add_s, res[W-1:4]};
                        cout      <= add_cout;
                        ovf       <= add_cout ^ add_c3;
                        carry     <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        carry <= add_cout;
                        cnt   <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder
// closing the add_* loop.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] op_a, op_b;
    logic        cin, in_valid, out_ready;
    logic        in_ready, cout, ovf, out_valid;
    logic [15:0] sum;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout, add_c3;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External 4-bit ripple adder: sum, carry out, and carry into bit 3.
    logic [4:0] full;
    logic [3:0] low3;
    assign full     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign low3     = {1'b0, add_a[2:0]} + {1'b0, add_b[2:0]} + {3'b0, add_cin};
    assign add_s    = full[3:0];
    assign add_cout = full[4];
    assign add_c3   = low3[3];

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
        .add_cout(add_cout), .add_c3(add_c3), .state_dbg(state_dbg)
    );

    // Presents operands for exactly one edge, then scrambles the inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 16'hdead; op_b = 16'hbeef; cin = ~c;
    endtask

    // Edges from acceptance until out_valid is seen; -1 if it never is.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = 16'h0; op_b = 16'h0; cin = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({sum, cout, ovf} !== 18'h0) begin errors++; $display("FAIL reset_result: got %h/%b/%b expected 0", sum, cout, ovf); end
        checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin errors++; $display("FAIL reset_adder: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h0004, 16'h0002, 1'b0);
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL basic_state_run: got %0d expected 1", state_dbg); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_run: got %b expected 0", in_ready); end
        checks++; if ({add_a, add_b, add_cin} !== {4'h4, 4'h2, 1'b0}) begin errors++; $display("FAIL basic_adder_nib0: got %h/%h/%b expected 4/2/0", add_a, add_b, add_cin); end
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h0006, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_result: got %h/%b/%b expected 0006/0/0", sum, cout, ovf); end
        checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin errors++; $display("FAIL basic_adder_done: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
        release_result();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL basic_release: got rdy=%b vld=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_carry();
        int lat;
        start_op(16'h0009, 16'h0007, 1'b1);
        checks++; if (add_cin !== 1'b1) begin errors++; $display("FAIL carry_cin_nib0: got %b expected 1", add_cin); end
        @(posedge clk); #1;
        checks++; if (add_cin !== 1'b1) begin errors++; $display("FAIL carry_nib1_cin: got %b expected 1", add_cin); end
        wait_done(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL carry_latency_rest: got %0d expected 3", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h0011, 1'b0, 1'b0}) begin errors++; $display("FAIL carry_result: got %h/%b/%b expected 0011/0/0", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_wrap_ovf();
        int lat;
        start_op(16'hffff, 16'h0001, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency: got %0d expected 4", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_result: got %h/%b/%b expected 0000/1/0", sum, cout, ovf); end
        release_result();
        start_op(16'h7fff, 16'h0001, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency: got %0d expected 4", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_result: got %h/%b/%b expected 8000/0/1", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_hold();
        int lat;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'h0f0f; op_b = 16'h0101;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({sum, out_valid, in_ready} !== {16'h5555, 1'b1, 1'b0}) begin errors++; $display("FAIL hold_cycle%0d: got %h/%b/%b expected 5555/1/0", i, sum, out_valid, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({state_dbg, in_ready, out_valid} !== {2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL hold_release: got st=%0d rdy=%b vld=%b expected 0/1/0", state_dbg, in_ready, out_valid); end
        repeat (2) @(posedge clk); #1;
        checks++; if ({sum, state_dbg} !== {16'h5555, 2'd0}) begin errors++; $display("FAIL idle_retain: got %h st=%0d expected 5555 st=0", sum, state_dbg); end
    endtask

    task automatic test_reset_abort();
        int seen;
        int lat;
        start_op(16'haaaa, 16'h5555, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid, state_dbg} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL abort_async_ctrl: got rdy=%b vld=%b st=%0d expected 1/0/0", in_ready, out_valid, state_dbg); end
        checks++; if ({sum, cout, ovf, add_a, add_b, add_cin} !== 27'h0) begin errors++; $display("FAIL abort_async_data: got %h/%b/%b/%h/%h/%b expected 0", sum, cout, ovf, add_a, add_b, add_cin); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
        start_op(16'h1234, 16'h1111, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL after_abort_latency: got %0d expected 4", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h2345, 1'b0, 1'b0}) begin errors++; $display("FAIL after_abort_result: got %h/%b/%b expected 2345/0/0", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(16'h8000, 16'h8000, 1'b0);
        wait_done(lat);
        checks++; if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL b2b_first: got %h/%b/%b expected 0000/1/1", sum, cout, ovf); end
        release_result();
        start_op(16'h0fff, 16'h0001, 1'b1);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        checks++; if ({sum, cout, ovf} !== {16'h1001, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_second: got %h/%b/%b expected 1001/0/0", sum, cout, ovf); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_wrap_ovf();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NIBBLES, NIBBLES >= 2).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port OP_A, input, W, the first operand.
REQ-005 The block SHALL have port OP_B, input, W, the second operand.
REQ-006 The block SHALL have port CIN, input, 1, the carry-in to the least-significant nibble.
REQ-007 The block SHALL have port IN_VALID, input, 1, meaning the operands are presented.
REQ-008 The block SHALL have port IN_READY, output, 1, meaning the block accepts operands.
REQ-009 The block SHALL have port SUM, output, W, the result.
REQ-010 The block SHALL have port COUT, output, 1, the final carry-out.
REQ-011 The block SHALL have port OVF, output, 1, signed two's-complement overflow.
REQ-012 The block SHALL have port OUT_VALID, output, 1, meaning the result is valid.
REQ-013 The block SHALL have port OUT_READY, input, 1, meaning the consumer takes the result.
REQ-014 The block SHALL have ports ADD_A and ADD_B, output, 4 each, which drive the external 4-bit adder's A and B.
REQ-015 The block SHALL have port ADD_CIN, output, 1, which drives the adder CIN.
REQ-016 The block SHALL have port ADD_S, input, 4, carrying the adder S.
REQ-017 The block SHALL have ports ADD_COUT and ADD_C3, input, 1 each, carrying the adder COUT and the carry into bit 3.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-019 IN_READY SHALL be 1 only in IDLE, and OUT_VALID SHALL be 1 only in DONE.
REQ-020 In IDLE, IN_VALID=1 at a rising edge SHALL latch OP_A, OP_B and CIN into internal registers, clear the nibble counter and move to RUN.
REQ-021 In IDLE with IN_VALID=0, the state SHALL be held.
REQ-022 In RUN, ADD_A and ADD_B SHALL equal the current low nibble of the latched operand shift registers, and ADD_CIN SHALL equal the registered carry, all driven from registers only.
REQ-023 On each RUN edge: ADD_S SHALL shift into the result register from the top (shift right by 4); ADD_COUT SHALL load the carry register; both operand registers SHALL shift right by 4; the counter SHALL increment.
REQ-024 On the RUN edge where the counter equals NIBBLES-1, the block SHALL set COUT<=ADD_COUT and OVF<=ADD_COUT xor ADD_C3, and move to DONE.
REQ-025 Latency SHALL be fixed: OUT_VALID SHALL rise exactly NIBBLES cycles after the accepting edge (4 cycles at default).
REQ-026 In DONE, SUM, COUT and OVF SHALL be held stable until OUT_READY=1 at an edge, which SHALL return the block to IDLE.
REQ-027 OUT_READY SHALL be ignored outside DONE, and IN_VALID SHALL be ignored outside IDLE.
REQ-028 SUM, COUT and OVF SHALL retain the last result in IDLE until the next DONE.
REQ-029 In IDLE and DONE, ADD_A, ADD_B and ADD_CIN SHALL drive 0.
REQ-030 Throughput SHALL be at most one operation per NIBBLES+2 cycles, and no acceptance SHALL occur in the same cycle as a result handshake.
REQ-031 Arithmetic SHALL be modulo 2^W, with the carry beyond bit W-1 reported only on COUT; wrap-around with no further effect SHALL be correct behaviour.

Reset
REQ-032 RST=1 SHALL immediately, without waiting for CLK, force the following: state IDLE; IN_READY=1; OUT_VALID=0; SUM=0; COUT=0; OVF=0; ADD_A=0; ADD_B=0; ADD_CIN=0; counter=0; all internal registers 0.
REQ-033 RST asserted during RUN or DONE SHALL abort the operation with no OUT_VALID pulse, and the first operation after release SHALL be unaffected.

Verification
REQ-034 The bench SHALL instantiate the block with the team's 4-bit adder closing the ADD_* loop, and SHALL cover the following directed cases.
REQ-035 OP_A=0x0004, OP_B=0x0002, CIN=0 -> SUM=0x0006, COUT=0, OVF=0, with OUT_VALID exactly 4 cycles after acceptance.
REQ-036 OP_A=0x0009, OP_B=0x0007, CIN=1 -> SUM=0x0011, COUT=0, OVF=0, with a carry propagating out of nibble 0.
REQ-037 OP_A=0xFFFF, OP_B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0; and OP_A=0x7FFF, OP_B=0x0001 -> SUM=0x8000, COUT=0, OVF=1.
REQ-038 With OUT_READY held 0 for 3 cycles in DONE -> SUM, OUT_VALID=1 and IN_READY=0 stay stable, and the block returns to IDLE one edge after OUT_READY=1.
REQ-039 RST pulsed at the second RUN cycle -> outputs go to reset values asynchronously, no OUT_VALID occurs, and the next operation 0x1234+0x1111 gives 0x2345.
